// File: rtl/pad_filter_pkg.sv
// Shared types and defaults for the pad input filter.
package pad_filter_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } pad_filt_state_e;

    localparam int unsigned DEBOUNCE_W_DEF = 16;
    localparam int unsigned NUM_PADS_DEF   = 8;

endpackage

// File: rtl/pad_filter_chan.sv
// One pad channel: 2-FF synchroniser, counter-based debounce FSM and
// registered rise/fall pulses.
module pad_filter_chan
    import pad_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_W = DEBOUNCE_W_DEF,
    parameter logic        RESET_VAL  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pad_in_i,
    input  logic                  cfg_en_i,
    input  logic [DEBOUNCE_W-1:0] cfg_cycles_i,
    output logic                  pad_val_o,
    output logic                  rise_o,
    output logic                  fall_o
);

    pad_filt_state_e       state;
    pad_filt_state_e       state_next;
    logic [DEBOUNCE_W-1:0] cnt;
    logic [DEBOUNCE_W-1:0] cnt_next;
    logic                  sync_q1;
    logic                  sync_q2;
    logic                  filt_next;
    logic                  rise_next;
    logic                  fall_next;
    logic                  bypass;

    assign bypass = (cfg_cycles_i == '0);

    // Synchroniser runs unconditionally so re-enable sees a settled level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q1   <= RESET_VAL;
            sync_q2   <= RESET_VAL;
            state     <= STABLE;
            cnt       <= '0;
            pad_val_o <= RESET_VAL;
            rise_o    <= 1'b0;
            fall_o    <= 1'b0;
        end else begin
            sync_q1   <= pad_in_i;
            sync_q2   <= sync_q1;
            state     <= state_next;
            cnt       <= cnt_next;
            pad_val_o <= filt_next;
            rise_o    <= rise_next;
            fall_o    <= fall_next;
        end
    end

    // Counter only advances while below the threshold, so it cannot wrap.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        filt_next  = pad_val_o;
        if (!cfg_en_i) begin
            state_next = STABLE;
            cnt_next   = '0;
        end else if (bypass) begin
            state_next = STABLE;
            cnt_next   = '0;
            filt_next  = sync_q2;
        end else begin
            case (state)
                STABLE: begin
                    if (sync_q2 != pad_val_o) begin
                        state_next = COUNT;
                        cnt_next   = DEBOUNCE_W'(1);
                    end else begin
                        cnt_next = '0;
                    end
                end
                COUNT: begin
                    if (sync_q2 == pad_val_o) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else if (cnt >= cfg_cycles_i) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                        filt_next  = sync_q2;
                    end else begin
                        cnt_next = cnt + DEBOUNCE_W'(1);
                    end
                end
                default: begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign rise_next = filt_next & ~pad_val_o;
    assign fall_next = ~filt_next & pad_val_o;

endmodule

// File: rtl/pad_input_filter.sv
// Pad input conditioning bank: NUM_PADS filter channels plus an optional
// sticky edge-interrupt bank enabled by PAD_INPUT_FILTER_IRQ_EN.
module pad_input_filter
    import pad_filter_pkg::*;
#(
    parameter int unsigned         NUM_PADS   = NUM_PADS_DEF,
    parameter int unsigned         DEBOUNCE_W = DEBOUNCE_W_DEF,
    parameter logic [NUM_PADS-1:0] RESET_VAL  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_PADS-1:0]   pad_in_i,
    input  logic [NUM_PADS-1:0]   cfg_en_i,
    input  logic [DEBOUNCE_W-1:0] cfg_cycles_i,
    output logic [NUM_PADS-1:0]   pad_val_o,
    output logic [NUM_PADS-1:0]   rise_o,
    output logic [NUM_PADS-1:0]   fall_o,
    input  logic [NUM_PADS-1:0]   irq_mask_i,
    input  logic [NUM_PADS-1:0]   irq_clr_i,
    output logic [NUM_PADS-1:0]   irq_status_o,
    output logic                  irq_o
);

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_chan
        pad_filter_chan #(
            .DEBOUNCE_W (DEBOUNCE_W),
            .RESET_VAL  (RESET_VAL[i])
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .pad_in_i     (pad_in_i[i]),
            .cfg_en_i     (cfg_en_i[i]),
            .cfg_cycles_i (cfg_cycles_i),
            .pad_val_o    (pad_val_o[i]),
            .rise_o       (rise_o[i]),
            .fall_o       (fall_o[i])
        );
    end

`ifdef PAD_INPUT_FILTER_IRQ_EN
    // Sticky status; a new edge in the same cycle as its clear keeps the bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_status_o <= '0;
            irq_o        <= 1'b0;
        end else begin
            irq_status_o <= (irq_status_o & ~irq_clr_i) | ((rise_o | fall_o) & irq_mask_i);
            irq_o        <= |irq_status_o;
        end
    end
`else
    logic unused_irq_cfg;
    assign unused_irq_cfg = ^{irq_mask_i, irq_clr_i};
    assign irq_status_o   = '0;
    assign irq_o          = 1'b0;
`endif

endmodule
